// File: rtl/d1spram_host.sv
// Request-side master for the d1spram single-port SRAM: optional zero-fill after reset,
// valid/ready request issue, one-cycle read capture and an in-order response FIFO.
module d1spram_host #(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 4096,
    parameter int RSP_DEPTH = 2,
    parameter bit INIT_EN   = 1'b1,
    localparam int AW       = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [3:0]       req_mask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_we,
    output logic             init_done,
    output logic             sram_wen,
    output logic             sram_ren,
    output logic [AW-1:0]    sram_waddr,
    output logic [AW-1:0]    sram_raddr,
    output logic [WIDTH-1:0] sram_wdata,
    output logic [3:0]       sram_mask,
    input  logic [WIDTH-1:0] sram_rdata
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 2);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    init_cnt;
    logic             inflight;
    logic             inflight_we;
    logic [WIDTH-1:0] fifo_data [RSP_DEPTH];
    logic             fifo_we   [RSP_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    occupancy;
    logic             run;
    logic             fire;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every output is gated by rst_n so nothing reaches the SRAM while reset is held.
    assign run       = rst_n && (state == ST_RUN);
    assign init_done = run;
    assign rsp_valid = rst_n && (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign push      = inflight;

    // A slot is reserved for the read/write still in flight, so the FIFO can never overflow.
    assign occupancy = count + CW'(inflight) - CW'(pop);
    assign req_ready = run && (occupancy < CW'(RSP_DEPTH));
    assign fire      = req_valid && req_ready;

    assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_we    = rsp_valid && fifo_we[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + AW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        sram_wen   = 1'b0;
        sram_ren   = 1'b0;
        sram_waddr = '0;
        sram_raddr = '0;
        sram_wdata = '0;
        sram_mask  = '0;
        if (rst_n) begin
            if (state == ST_INIT) begin
                sram_wen  = 1'b1;
                sram_waddr = init_cnt;
                sram_mask = 4'hF;
                if (init_cnt == AW'(SIZE - 1)) begin
                    state_next = ST_RUN;
                end
            end else if (fire) begin
                if (req_we) begin
                    sram_wen   = 1'b1;
                    sram_waddr = req_addr;
                    sram_wdata = req_wdata;
                    sram_mask  = req_mask;
                end else begin
                    sram_ren   = 1'b1;
                    sram_raddr = req_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_we <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight    <= fire;
            inflight_we <= req_we;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= inflight_we ? '0 : sram_rdata;
            fifo_we[wr_ptr]   <= inflight_we;
        end
    end

endmodule

// File: tb/tb_d1spram_host.sv
// Directed bench for d1spram_host with a behavioural SRAM and an expected-response queue.
module tb_d1spram_host;

    localparam int WIDTH     = 32;
    localparam int SIZE      = 16;
    localparam int RSP_DEPTH = 2;
    localparam int AW        = $clog2(SIZE);

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we    = 1'b0;
    logic [AW-1:0]    req_addr  = '0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic [3:0]       req_mask  = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_we;
    logic             init_done;
    logic             sram_wen;
    logic             sram_ren;
    logic [AW-1:0]    sram_waddr;
    logic [AW-1:0]    sram_raddr;
    logic [WIDTH-1:0] sram_wdata;
    logic [3:0]       sram_mask;
    logic [WIDTH-1:0] sram_rdata;

    logic [WIDTH-1:0] sram_mem [SIZE];
    logic [WIDTH-1:0] ref_mem  [SIZE];
    logic [32:0]      exp_q [$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int fires     = 0;
    int pops      = 0;
    int first_pop = -1;
    int last_pop  = -1;

    d1spram_host #(
        .WIDTH(WIDTH), .SIZE(SIZE), .RSP_DEPTH(RSP_DEPTH), .INIT_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_we(rsp_we),
        .init_done(init_done),
        .sram_wen(sram_wen), .sram_ren(sram_ren), .sram_waddr(sram_waddr), .sram_raddr(sram_raddr),
        .sram_wdata(sram_wdata), .sram_mask(sram_mask), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model; contents are scrambled while reset is held so only the zero-fill can clear them.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SIZE; k++) sram_mem[k] <= 32'hA5A5_0000 | 32'(k);
            sram_rdata <= 32'hBAD0_0BAD;
        end else begin
            if (sram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (sram_mask[b]) sram_mem[sram_waddr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
            if (sram_ren) sram_rdata <= sram_mem[sram_raddr];
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive after the falling edge, then sample and score.
    task automatic apply_stimulus(input logic v, input logic we, input logic [AW-1:0] a,
                                  input logic [31:0] d, input logic [3:0] m, input logic rr);
        logic [45:0] exp_issue;
        logic [31:0] t;
        logic [32:0] e;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_mask  = m;
        rsp_ready = rr;
        #1;
        cyc++;
        if (req_valid && req_ready) begin
            fires++;
            exp_issue = we ? {2'b10, a, {AW{1'b0}}, d, m} : {2'b01, {AW{1'b0}}, a, 32'h0, 4'h0};
            check_output("issue", {sram_wen, sram_ren, sram_waddr, sram_raddr, sram_wdata, sram_mask},
                         exp_issue);
            if (we) begin
                exp_q.push_back({32'h0, 1'b1});
                t = ref_mem[a];
                for (int b = 0; b < 4; b++) if (m[b]) t[8*b +: 8] = d[8*b +: 8];
                ref_mem[a] = t;
            end else begin
                exp_q.push_back({ref_mem[a], 1'b0});
            end
        end
        if (rsp_valid && rsp_ready) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (exp_q.size() == 0) begin
                check_output("rsp_unexpected", 64'(rsp_valid), 64'h0);
            end else begin
                e = exp_q.pop_front();
                check_output("rsp", {rsp_rdata, rsp_we}, e);
            end
        end
    endtask

    task automatic idle(input logic rr);
        apply_stimulus(1'b0, 1'b0, '0, 32'h0, 4'h0, rr);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            idle(1'b1);
            n++;
        end
        check_output("drain", 64'(exp_q.size()), 64'h0);
    endtask

    // Reset asynchronously, then follow the zero-fill sweep cycle by cycle.
    task automatic reset_and_init(input string tag);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        for (int k = 0; k < SIZE; k++) ref_mem[k] = '0;
        #1;
        check_output({tag, "_rst_ctrl"},
                     {req_ready, rsp_valid, rsp_we, init_done, sram_wen, sram_ren,
                      sram_mask, sram_waddr, sram_raddr}, 64'h0);
        check_output({tag, "_rst_data"}, {rsp_rdata, sram_wdata}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check_output({tag, "_init_cycle"},
                         {init_done, req_ready, sram_wen, sram_ren, sram_waddr, sram_wdata, sram_mask},
                         {1'b0, 1'b0, 1'b1, 1'b0, AW'(i), 32'h0, 4'hF});
        end
        @(negedge clk);
        #1;
        check_output({tag, "_init_done"}, {init_done, sram_wen, req_ready}, 3'b101);
    endtask

    initial begin
        int f0;
        int p0;
        #2;
        reset_and_init("boot");

        $display("[TB] zero-fill readback");
        apply_stimulus(1'b1, 1'b0, AW'(5), 32'h0, 4'h0, 1'b1);
        drain();
        check_output("idle_port", {sram_wen, sram_ren}, 2'b00);

        $display("[TB] write then read with latency check");
        apply_stimulus(1'b1, 1'b1, AW'(3), 32'hDEAD_BEEF, 4'hF, 1'b1);
        drain();
        apply_stimulus(1'b1, 1'b0, AW'(3), 32'h0, 4'h0, 1'b1);
        idle(1'b1);
        check_output("lat_t1", 64'(rsp_valid), 64'h0);
        idle(1'b1);
        check_output("lat_t2", {rsp_valid, rsp_rdata}, {1'b1, 32'hDEAD_BEEF});
        drain();

        $display("[TB] byte mask merge");
        apply_stimulus(1'b1, 1'b1, AW'(7), 32'h1122_3344, 4'hF, 1'b1);
        apply_stimulus(1'b1, 1'b1, AW'(7), 32'hAABB_CCDD, 4'b0101, 1'b1);
        apply_stimulus(1'b1, 1'b1, AW'(7), 32'hFFFF_FFFF, 4'b0000, 1'b1);
        apply_stimulus(1'b1, 1'b0, AW'(7), 32'h0, 4'h0, 1'b1);
        drain();
        check_output("mask_ref", 64'(ref_mem[7]), 64'h11BB_33DD);

        $display("[TB] backpressure");
        for (int a = 8; a < 12; a++)
            apply_stimulus(1'b1, 1'b1, AW'(a), 32'hC0DE_0000 | 32'(a), 4'hF, 1'b1);
        drain();
        f0 = fires;
        p0 = pops;
        for (int i = 0; i < 6; i++)
            apply_stimulus(1'b1, 1'b0, AW'(8 + fires - f0), 32'h0, 4'h0, 1'b0);
        check_output("bp_accepted", 64'(fires - f0), 64'(RSP_DEPTH));
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, AW'(10), 32'h0, 4'h0, 1'b0);
            check_output("bp_head", {req_ready, rsp_valid, rsp_rdata, rsp_we},
                         {1'b0, 1'b1, 32'hC0DE_0008, 1'b0});
        end
        drain();
        check_output("bp_returned", 64'(pops - p0), 64'(RSP_DEPTH));

        $display("[TB] back-to-back reads");
        f0 = fires;
        p0 = pops;
        first_pop = -1;
        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b1, 1'b0, AW'(4 + i), 32'h0, 4'h0, 1'b1);
        check_output("b2b_fires", 64'(fires - f0), 64'd8);
        drain();
        check_output("b2b_pops", 64'(pops - p0), 64'd8);
        check_output("b2b_span", 64'(last_pop - first_pop), 64'd7);

        $display("[TB] reset with traffic pending");
        apply_stimulus(1'b1, 1'b0, AW'(3), 32'h0, 4'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, AW'(7), 32'h0, 4'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, AW'(9), 32'h0, 4'h0, 1'b0);
        check_output("pre_rst_pending", {rsp_valid, req_ready}, 2'b10);
        reset_and_init("mid");
        p0 = pops;
        for (int i = 0; i < 6; i++) idle(1'b1);
        check_output("no_stale", 64'(pops - p0), 64'h0);
        apply_stimulus(1'b1, 1'b0, AW'(3), 32'h0, 4'h0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
